pair_scheduler: RTL and testbench

PAIR_SCHEDULER -- requirements
Module: pair_scheduler

---
 rtl/pair_scheduler.sv | 137 +++++++++++++
 tb/tb_pair_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pair_scheduler.sv
// Streams every ordered (i, j) particle pair, i != j, out of a small position store.
// Pair outputs are registered and advance only on a valid/ready transfer.
module pair_scheduler #(
  parameter int unsigned N_MAX = 16,
  parameter int unsigned IW    = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ld_en,
  input  logic [IW-1:0]        ld_addr,
  input  logic signed [15:0]   ld_x,
  input  logic signed [15:0]   ld_y,
  input  logic                 start,
  input  logic [IW:0]          n_particles,
  output logic                 pair_valid,
  input  logic                 pair_ready,
  output logic signed [15:0]   x_i,
  output logic signed [15:0]   y_i,
  output logic signed [15:0]   x_j,
  output logic signed [15:0]   y_j,
  output logic [IW-1:0]        idx_i,
  output logic [IW-1:0]        idx_j,
  output logic                 last_j,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  localparam logic [IW:0] NMax = (IW+1)'(N_MAX);

  state_e        state_q, state_d;
  logic [31:0]   mem_q [N_MAX];
  logic [IW-1:0] i_q, i_d, j_q, j_d, nm1_q, nm1_d;
  logic          valid_q, valid_d, last_q, last_d;
  logic [31:0]   pi_q, pj_q;
  logic [IW:0]   n_clamp;
  logic [IW-1:0] j_inc, j_inc2;
  logic          xfer, load;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    nm1_d   = nm1_q;
    valid_d = valid_q;
    load    = 1'b0;
    n_clamp = (n_particles > NMax) ? NMax : n_particles;
    xfer    = valid_q && pair_ready;
    j_inc   = j_q + IW'(1);
    j_inc2  = j_q + IW'(2);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          nm1_d = n_clamp[IW-1:0] - IW'(1);
          if (n_clamp >= (IW+1)'(2)) begin
            state_d = StRun;
            i_d     = '0;
            j_d     = IW'(1);
            valid_d = 1'b1;
            load    = 1'b1;
          end else begin
            state_d = StFin;
          end
        end
      end
      StRun: begin
        if (xfer) begin
          if (last_q) begin
            if (i_q == nm1_q) begin
              state_d = StFin;
              valid_d = 1'b0;
            end else begin
              i_d  = i_q + IW'(1);
              j_d  = '0;
              load = 1'b1;
            end
          end else begin
            // Step j, hopping over the diagonal.
            j_d  = (j_inc == i_q) ? j_inc2 : j_inc;
            load = 1'b1;
          end
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    last_d = (j_d == nm1_d) || ((i_d == nm1_d) && (j_d == nm1_d - IW'(1)));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      nm1_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pi_q    <= '0;
      pj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      nm1_q   <= nm1_d;
      valid_q <= valid_d;
      if (load) begin
        last_q <= last_d;
        pi_q   <= mem_q[i_d];
        pj_q   <= mem_q[j_d];
      end
    end
  end

  // Writes are only accepted while idle so a sweep sees a frozen store.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < int'(N_MAX); k++) mem_q[k] <= '0;
    end else if (ld_en && (state_q == StIdle)) begin
      mem_q[ld_addr] <= {ld_x, ld_y};
    end
  end

  assign pair_valid = valid_q;
  assign x_i        = pi_q[31:16];
  assign y_i        = pi_q[15:0];
  assign x_j        = pj_q[31:16];
  assign y_j        = pj_q[15:0];
  assign idx_i      = i_q;
  assign idx_j      = j_q;
  assign last_j     = last_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);

endmodule

// File: tb/tb_pair_scheduler.sv
// Directed bench for pair_scheduler: pair order, handshake hold, clamping, reset abort.
module tb_pair_scheduler;

  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              ld_en;
  logic [IW-1:0]     ld_addr;
  logic signed [15:0] ld_x, ld_y;
  logic              start;
  logic [IW:0]       n_particles;
  logic              pair_valid;
  logic              pair_ready;
  logic signed [15:0] x_i, y_i, x_j, y_j;
  logic [IW-1:0]     idx_i, idx_j;
  logic              last_j, busy, done;

  int checks = 0;
  int failures = 0;

  int qi[$], qj[$], ql[$], qxi[$], qyi[$], qxj[$], qyj[$];
  int ndone, done_at, last_xfer, cnt;
  int tx[3] = '{1, -3, 5};
  int ty[3] = '{2, 4, -6};

  pair_scheduler #(.N_MAX(16), .IW(IW)) dut (
    .clk(clk), .rstn(rstn), .ld_en(ld_en), .ld_addr(ld_addr), .ld_x(ld_x), .ld_y(ld_y),
    .start(start), .n_particles(n_particles), .pair_valid(pair_valid),
    .pair_ready(pair_ready), .x_i(x_i), .y_i(y_i), .x_j(x_j), .y_j(y_j),
    .idx_i(idx_i), .idx_j(idx_j), .last_j(last_j), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input int x, input int y);
    ld_en = 1'b1; ld_addr = IW'(addr); ld_x = 16'(x); ld_y = 16'(y);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the edge that sampled start.
  task automatic do_start(input int n);
    start = 1'b1; n_particles = (IW+1)'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready alternates 1/0. inject: ld_en + start mid-run.
  task automatic sweep(input int mode, input bit inject, input int max_cyc);
    bit held = 0;
    bit finished = 0;
    bit rdy;
    logic [79:0] snap = '0;
    logic [79:0] cur;
    qi.delete(); qj.delete(); ql.delete();
    qxi.delete(); qyi.delete(); qxj.delete(); qyj.delete();
    ndone = 0; done_at = -1; last_xfer = -1;
    for (int c = 0; c < max_cyc; c++) begin
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (!busy) begin
        finished = 1;
        break;
      end
      cur = {pair_valid, last_j, idx_i, idx_j, x_i, y_i, x_j, y_j};
      if (held) check("hold", cur, snap);
      rdy = (mode == 0) || (c % 2 == 0);
      pair_ready = rdy;
      if (inject && c == 1) begin
        ld_en = 1'b1; ld_addr = '0; ld_x = 16'sd99; ld_y = 16'sd99;
        start = 1'b1; n_particles = (IW+1)'(2);
      end else begin
        ld_en = 1'b0; start = 1'b0;
      end
      if (pair_valid && rdy) begin
        qi.push_back(int'(idx_i)); qj.push_back(int'(idx_j)); ql.push_back(int'(last_j));
        qxi.push_back(int'(x_i)); qyi.push_back(int'(y_i));
        qxj.push_back(int'(x_j)); qyj.push_back(int'(y_j));
        last_xfer = c;
      end
      held = pair_valid && !rdy;
      snap = cur;
      @(negedge clk);
    end
    pair_ready = 1'b0; ld_en = 1'b0; start = 1'b0;
    check("sweep_terminates", 80'(finished), 80'(1));
  endtask

  // pmode 0: positions from the loaded table; 1: all zero; 2: positions not checked.
  task automatic check_pairs(input int n, input int pmode, input string tag);
    int nn = (n > 16) ? 16 : n;
    int k = 0;
    int errs = 0;
    int maxj;
    for (int i = 0; i < nn; i++) begin
      for (int j = 0; j < nn; j++) begin
        if (i != j) begin
          maxj = (i == nn - 1) ? nn - 2 : nn - 1;
          if (k >= qi.size()) errs++;
          else begin
            if (qi[k] != i || qj[k] != j || ql[k] != int'(j == maxj)) errs++;
            if (pmode == 0 && (qxi[k] != tx[i] || qyi[k] != ty[i] ||
                               qxj[k] != tx[j] || qyj[k] != ty[j])) errs++;
            if (pmode == 1 && (qxi[k] != 0 || qyi[k] != 0 || qxj[k] != 0 || qyj[k] != 0))
              errs++;
          end
          k++;
        end
      end
    end
    check({tag, "_count"}, 80'(qi.size()), 80'(nn * (nn - 1)));
    check({tag, "_order"}, 80'(errs), 80'(0));
  endtask

  initial begin
    int fi, fj;
    rstn = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_x = '0; ld_y = '0;
    start = 1'b0; n_particles = '0; pair_ready = 1'b0;
    #1;
    check("rst_valid", 80'(pair_valid), 80'(0));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_done", 80'(done), 80'(0));
    check("rst_outs", {last_j, idx_i, idx_j, x_i, y_i, x_j, y_j}, 80'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    load(0, 1, 2);
    load(1, -3, 4);
    load(2, 5, -6);

    // Full throughput N=3.
    do_start(3);
    check("n3_first_valid", 80'(pair_valid), 80'(1));
    check("n3_first_idx", {idx_i, idx_j}, {4'd0, 4'd1});
    check("n3_first_pos", {x_i, y_i, x_j, y_j}, {16'sd1, 16'sd2, -16'sd3, 16'sd4});
    sweep(0, 0, 40);
    check_pairs(3, 0, "n3_full");
    check("n3_full_last_j_02", 80'(ql.size() > 1 ? ql[1] : -1), 80'(1));
    check("n3_full_done_lat", 80'(done_at), 80'(last_xfer + 1));
    check("n3_full_done_once", 80'(ndone), 80'(1));

    // Ready toggling: outputs must hold on the idle half.
    do_start(3);
    sweep(1, 0, 60);
    check_pairs(3, 0, "n3_toggle");
    check("n3_toggle_done_lat", 80'(done_at), 80'(last_xfer + 1));

    // Write and restart attempts mid-sweep are ignored.
    do_start(3);
    sweep(0, 1, 40);
    check_pairs(3, 0, "n3_inject");
    check("n3_inject_done_once", 80'(ndone), 80'(1));

    // N=1 and N=0: straight to FIN, done in the cycle after the start edge.
    for (int n = 1; n >= 0; n--) begin
      do_start(n);
      check("small_n_valid", 80'(pair_valid), 80'(0));
      check("small_n_done", {done, busy}, {1'b1, 1'b1});
      @(negedge clk);
      check("small_n_idle", {done, busy, pair_valid}, {1'b0, 1'b0, 1'b0});
    end

    // Over-range count clamps to 16 particles.
    do_start(31);
    sweep(0, 0, 400);
    check_pairs(31, 2, "n31");
    fi = (qi.size() > 0) ? qi[qi.size() - 1] : -1;
    fj = (qj.size() > 0) ? qj[qj.size() - 1] : -1;
    check("n31_final_pair", {32'(fi), 32'(fj)}, {32'd15, 32'd14});

    // Reset after the third pair transfer.
    do_start(3);
    pair_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 3; c++) begin
      if (pair_valid) cnt++;
      @(negedge clk);
    end
    check("abort_fourth_pair", {pair_valid, idx_i, idx_j}, {1'b1, 4'd1, 4'd2});
    rstn = 1'b0;
    #1;
    check("abort_valid", 80'(pair_valid), 80'(0));
    check("abort_busy_done", {busy, done}, {1'b0, 1'b0});
    @(negedge clk);
    rstn = 1'b1;
    pair_ready = 1'b0;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", 80'(ndone), 80'(0));
    do_start(3);
    sweep(0, 0, 40);
    check_pairs(3, 1, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
